morse_tx_engine: RTL and testbench
==================================

Name: morse_tx_engine

Overview:
- Parametrised Morse keying engine that replaces the fixed buffer-plus-blinker pair.
- Accepts packed Morse codewords from the translator through a valid/ready write port and queues them in an internal FIFO of configurable depth.
- Drives a single key output (LED/buzzer) with exact dot/dash/gap unit timing.
- Adds back-pressure, a sticky overflow flag, a word-space symbol, flush and a FIFO level output.

Parameters:
- CODE_W, 20, codeword width in bits; must be even; holds CODE_W/2 two-bit symbols.
- DEPTH, 8, FIFO depth in codewords; power of two, ≥2.
- UNIT_CYCLES, 2400000, clock cycles per Morse time unit (200 ms at 12 MHz).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_wr_valid  in  1  codeword write request.
- i_wr_data  in  CODE_W  codeword, symbols packed MSB-first.
- o_wr_ready  out  1  FIFO not full; a write is accepted when i_wr_valid && o_wr_ready.
- i_flush  in  1  synchronous clear of FIFO and engine.
- i_clr_ovf  in  1  clears o_overflow.
- o_key  out  1  key output, high = mark.
- o_busy  out  1  engine active or FIFO non-empty.
- o_overflow  out  1  sticky: a write was refused.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (i_rst low, asynchronous), all outputs:
  - o_key=0, o_busy=0, o_overflow=0, o_level=0, o_wr_ready=1.
  - FSM goes to IDLE; FIFO pointers cleared.
- Symbol encoding, MSB pair first:
  - 00 = end of codeword.
  - 01 = dot.
  - 10 = dash.
  - 11 = word space.
- FIFO:
  - o_wr_ready = !full, based on registered state only.
  - A write while full is refused even if a pop occurs the same cycle.
  - A refused write (valid && !ready) sets o_overflow on the next edge.
  - o_overflow clears only on i_clr_ovf or reset; if set and clear coincide, set wins.
  - Simultaneous push and pop when non-empty and non-full: o_level is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop into the shift register and go to DECODE.
  - DECODE: examine the top symbol pair.
    - 01: o_key=1 for 1 unit, state MARK.
    - 10: o_key=1 for 3 units, state MARK.
    - 11: o_key=0 for 7 units, state WSPACE.
    - 00, or all CODE_W/2 symbols consumed: if the last symbol was a mark, o_key=0 for 3 units (CGAP); otherwise go straight to IDLE.
  - MARK end: if the next symbol is 01 or 10, o_key=0 for 1 unit (SGAP), then DECODE; otherwise DECODE directly.
  - WSPACE end: go to DECODE; no extra gap is added.
  - CGAP end: go to IDLE.
- All-zero codeword: consumed with no key activity.
- Timing:
  - N units = exactly N·UNIT_CYCLES cycles.
  - The unit counter reloads on every state change.
- Latency, engine idle and FIFO empty:
  - Write accepted on edge t; FIFO non-empty after t.
  - Pop on edge t+1; o_key (registered) high after edge t+2.
- Back-to-back codewords: the next codeword's first mark follows the CGAP immediately via IDLE. The IDLE→DECODE pop adds 1 cycle, and the bench allows for it.
- o_busy = (state≠IDLE) || (o_level≠0).
- i_flush:
  - Next edge: FIFO emptied, FSM to IDLE, o_key=0.
  - A write in the same cycle is dropped and does not set o_overflow.
- Reset mid-operation: o_key drops immediately (asynchronous); queued data is lost.

Test Plan:
- UNIT_CYCLES=4, DEPTH=4 in all cases.
- Write 0x40000 ("E") -> o_key high 4 cycles, then low 12 cycles (CGAP), then o_busy=0; o_overflow=0.
- Write 0x60000 ("A") -> o_key pattern high 4, low 4, high 12, low 12; o_level returns to 0 one cycle after the write.
- Write 0x40000 then 0xC0000 -> "E" timing, then key low for a further 28 cycles with o_busy=1 throughout, then idle.
- Write 0x55555 (10 dots, no terminator) -> 10 marks of 4 cycles separated by 9 gaps of 4 cycles, then 12 low; 88 cycles total from first key high.
- Six consecutive-cycle writes of 0x40000 -> first popped, next four fill to o_level=4, o_wr_ready=0; sixth refused and o_overflow=1. Pulsing i_clr_ovf -> o_overflow=0.
- Assert i_rst low mid-dash with o_level=2 -> o_key=0 immediately; o_level=0, o_busy=0, o_overflow=0. After release, a new write behaves as in the first scenario.

Source files
------------

// File: rtl/morse_tx_engine.sv
// morse_tx_engine
//   Morse keying engine: a codeword FIFO feeding a symbol sequencer that
//   drives one key output with unit-accurate mark/space timing.
//   Codewords hold CODE_W/2 two-bit symbols, MSB pair first:
//     00 end, 01 dot (1 unit), 10 dash (3 units), 11 word space (7 units).
//   Ports:
//     i_clk, i_rst      clock, asynchronous active-low reset
//     i_wr_valid/data   codeword write; accepted when o_wr_ready is high
//     o_wr_ready        FIFO not full (registered state only)
//     i_flush           synchronous clear of FIFO and sequencer
//     i_clr_ovf         clears the sticky overflow flag
//     o_key             key output, high = mark
//     o_busy            sequencer active or FIFO non-empty
//     o_overflow        sticky: a write was refused
//     o_level           FIFO occupancy
module morse_tx_engine #(
   parameter int CODE_W      = 20,
   parameter int DEPTH       = 8,
   parameter int UNIT_CYCLES = 2400000
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wr_valid,
   input  logic [CODE_W-1:0]        i_wr_data,
   output logic                     o_wr_ready,
   input  logic                     i_flush,
   input  logic                     i_clr_ovf,
   output logic                     o_key,
   output logic                     o_busy,
   output logic                     o_overflow,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW   = $clog2(DEPTH);
   localparam int NSYM = CODE_W / 2;
   localparam int SW   = $clog2(NSYM + 1);
   localparam int CW   = $clog2(7 * UNIT_CYCLES);
   // Counter reload values: a state lasting N units counts N*UNIT_CYCLES-1 .. 0.
   localparam logic [CW-1:0] T1 = CW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] T3 = CW'(3 * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] T7 = CW'(7 * UNIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, DECODE, MARK, SGAP, WSPACE, CGAP} state_t;

   logic [CODE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]       level_q, level_d;
   logic              ovf_q, ovf_d;
   state_t            state_q, state_d;
   logic              key_q, key_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CODE_W-1:0] sh_q, sh_d;
   logic [SW-1:0]     left_q, left_d;
   logic              last_mark_q, last_mark_d;

   logic       full, empty, push, pop, do_dec;
   logic [1:0] top;

   assign full  = (level_q == (AW+1)'(DEPTH));
   assign empty = (level_q == '0);
   // Flush wins over both ends of the FIFO.
   assign push  = i_wr_valid && !full && !i_flush;
   assign pop   = (state_q == IDLE) && !empty && !i_flush;
   // Shift register is pre-shifted after each consume, so the top pair is
   // always the next unconsumed symbol.
   assign top   = sh_q[CODE_W-1 -: 2];

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      ovf_d       = ovf_q;
      state_d     = state_q;
      key_d       = key_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      left_d      = left_q;
      last_mark_d = last_mark_q;
      do_dec      = 1'b0;

      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end

      // Set beats clear; a write dropped by flush is not a refusal.
      if (i_wr_valid && full && !i_flush) ovf_d = 1'b1;
      else if (i_clr_ovf)                 ovf_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (pop) begin
               sh_d        = mem_q[rd_ptr_q];
               left_d      = SW'(NSYM);
               last_mark_d = 1'b0;
               state_d     = DECODE;
            end
         end
         DECODE: do_dec = 1'b1;
         MARK: begin
            if (cnt_q == '0) begin
               // Inter-symbol gap only between two marks.
               if (left_q != '0 && (top[1] ^ top[0])) begin
                  state_d = SGAP;
                  key_d   = 1'b0;
                  cnt_d   = T1;
               end else begin
                  do_dec = 1'b1;
               end
            end else cnt_d = cnt_q - CW'(1);
         end
         SGAP, WSPACE: begin
            if (cnt_q == '0) do_dec = 1'b1;
            else             cnt_d  = cnt_q - CW'(1);
         end
         CGAP: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase

      // Decode is folded into the edge that ends the previous timed state so
      // every mark and space inside a codeword is exactly N units long.
      if (do_dec) begin
         if (left_q == '0 || top == 2'b00) begin
            key_d   = 1'b0;
            state_d = last_mark_q ? CGAP : IDLE;
            cnt_d   = T3;
         end else begin
            sh_d        = sh_q << 2;
            left_d      = left_q - SW'(1);
            last_mark_d = (top != 2'b11);
            case (top)
               2'b01:   begin state_d = MARK;   key_d = 1'b1; cnt_d = T1; end
               2'b10:   begin state_d = MARK;   key_d = 1'b1; cnt_d = T3; end
               default: begin state_d = WSPACE; key_d = 1'b0; cnt_d = T7; end
            endcase
         end
      end

      if (i_flush) begin
         state_d = IDLE;
         key_d   = 1'b0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         ovf_q       <= 1'b0;
         state_q     <= IDLE;
         key_q       <= 1'b0;
         cnt_q       <= '0;
         sh_q        <= '0;
         left_q      <= '0;
         last_mark_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         ovf_q       <= ovf_d;
         state_q     <= state_d;
         key_q       <= key_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         left_q      <= left_d;
         last_mark_q <= last_mark_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers/level.
   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q] <= i_wr_data;
   end

   assign o_wr_ready = !full;
   assign o_key      = key_q;
   assign o_busy     = (state_q != IDLE) || (level_q != '0);
   assign o_overflow = ovf_q;
   assign o_level    = level_q;
endmodule

// File: tb/tb_morse_tx_engine.sv
module tb_morse_tx_engine;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_valid = 1'b0;
   logic [19:0] wr_data = '0;
   logic        wr_ready;
   logic        flush = 1'b0;
   logic        clr_ovf = 1'b0;
   logic        key, busy, ovf;
   logic [2:0]  level;

   int n_pass = 0;
   int n_total = 0;

   logic       kq [256];
   logic       bq [256];
   logic [2:0] lq [256];

   morse_tx_engine #(.CODE_W(20), .DEPTH(4), .UNIT_CYCLES(4)) dut (
      .i_clk(clk), .i_rst(rst_n), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
      .o_wr_ready(wr_ready), .i_flush(flush), .i_clr_ovf(clr_ovf),
      .o_key(key), .o_busy(busy), .o_overflow(ovf), .o_level(level)
   );

   always #5 clk = ~clk;

   // One-cycle write; returns 1 time unit after the accepting edge (edge t).
   task automatic wr(input logic [19:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   // Sample i is taken between edge t+i and t+i+1 (t = last write edge).
   task automatic grab(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         kq[i] = key;
         bq[i] = busy;
         lq[i] = level;
      end
   endtask

   function automatic int run_len(input int s, input logic lvl);
      int n = 0;
      while (s + n < 256 && kq[s+n] === lvl) n++;
      return n;
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_total++; if (key !== 1'b0)      $display("FAIL rst_key: got %b want 0", key); else n_pass++;
      n_total++; if (busy !== 1'b0)     $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (ovf !== 1'b0)      $display("FAIL rst_ovf: got %b want 0", ovf); else n_pass++;
      n_total++; if (level !== 3'd0)    $display("FAIL rst_level: got %0d want 0", level); else n_pass++;
      n_total++; if (wr_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", wr_ready); else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_e(input string tag);
      int len;
      wr(20'h40000);
      grab(40);
      n_total++; if (lq[0] !== 3'd1) $display("FAIL %s_level0: got %0d want 1", tag, lq[0]); else n_pass++;
      n_total++; if (kq[1] !== 1'b0 || kq[2] !== 1'b1)
         $display("FAIL %s_latency: got %b%b want 01", tag, kq[1], kq[2]); else n_pass++;
      len = run_len(2, 1'b1);
      n_total++; if (len !== 4) $display("FAIL %s_dot_len: got %0d want 4", tag, len); else n_pass++;
      len = run_len(6, 1'b0);
      n_total++; if (len < 12) $display("FAIL %s_cgap_len: got %0d want >=12", tag, len); else n_pass++;
      n_total++; if (bq[17] !== 1'b1 || bq[18] !== 1'b0)
         $display("FAIL %s_busy_end: got %b%b want 10", tag, bq[17], bq[18]); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL %s_ovf: got %b want 0", tag, ovf); else n_pass++;
   endtask

   task automatic test_a();
      int len;
      wr(20'h60000);
      grab(60);
      n_total++; if (lq[0] !== 3'd1 || lq[1] !== 3'd0)
         $display("FAIL a_level: got %0d,%0d want 1,0", lq[0], lq[1]); else n_pass++;
      len = run_len(2, 1'b1);
      n_total++; if (len !== 4)  $display("FAIL a_dot: got %0d want 4", len); else n_pass++;
      len = run_len(6, 1'b0);
      n_total++; if (len !== 4)  $display("FAIL a_sgap: got %0d want 4", len); else n_pass++;
      len = run_len(10, 1'b1);
      n_total++; if (len !== 12) $display("FAIL a_dash: got %0d want 12", len); else n_pass++;
      len = run_len(22, 1'b0);
      n_total++; if (len < 12)   $display("FAIL a_cgap: got %0d want >=12", len); else n_pass++;
      n_total++; if (bq[33] !== 1'b1 || bq[34] !== 1'b0)
         $display("FAIL a_busy_end: got %b%b want 10", bq[33], bq[34]); else n_pass++;
   endtask

   // Samples relative to the second write edge: E mark at 1..4, CGAP 5..16,
   // then 28 cycles of word space (plus codeword start overhead).
   task automatic test_e_wspace();
      int bad_key, first_idle, busy_drop;
      wr(20'h40000);
      wr(20'hC0000);
      grab(70);
      n_total++; if (kq[0] !== 1'b0 || kq[1] !== 1'b1 || run_len(1, 1'b1) !== 4)
         $display("FAIL ew_mark: got len %0d want 4", run_len(1, 1'b1)); else n_pass++;
      bad_key = 0;
      for (int i = 5; i < 70; i++) if (kq[i] !== 1'b0) bad_key++;
      n_total++; if (bad_key != 0) $display("FAIL ew_key_low: got %0d high samples want 0", bad_key); else n_pass++;
      busy_drop = 0;
      for (int i = 0; i <= 44; i++) if (bq[i] !== 1'b1) busy_drop++;
      n_total++; if (busy_drop != 0) $display("FAIL ew_busy_held: got %0d idle samples want 0", busy_drop); else n_pass++;
      first_idle = -1;
      for (int i = 69; i >= 0; i--) if (bq[i] === 1'b0) first_idle = i;
      n_total++; if (first_idle < 45 || first_idle > 50)
         $display("FAIL ew_busy_end: got idle at %0d want 45..50", first_idle); else n_pass++;
   endtask

   task automatic test_dots();
      int idx, len;
      wr(20'h55555);
      grab(120);
      n_total++; if (kq[1] !== 1'b0 || kq[2] !== 1'b1)
         $display("FAIL dots_latency: got %b%b want 01", kq[1], kq[2]); else n_pass++;
      idx = 2;
      for (int k = 0; k < 10; k++) begin
         len = run_len(idx, 1'b1);
         n_total++; if (len !== 4) $display("FAIL dots_mark%0d: got %0d want 4", k, len); else n_pass++;
         idx += len;
         if (k < 9) begin
            len = run_len(idx, 1'b0);
            n_total++; if (len !== 4) $display("FAIL dots_gap%0d: got %0d want 4", k, len); else n_pass++;
            idx += len;
         end
      end
      n_total++; if (run_len(78, 1'b0) < 12)
         $display("FAIL dots_cgap: got %0d want >=12", run_len(78, 1'b0)); else n_pass++;
      // 88 cycles from first key high (sample 2) to idle (sample 90).
      n_total++; if (bq[89] !== 1'b1 || bq[90] !== 1'b0)
         $display("FAIL dots_total: got %b%b want 10", bq[89], bq[90]); else n_pass++;
   endtask

   task automatic test_overflow_flush();
      logic [2:0] exp_lvl [6];
      logic       exp_rdy [6];
      logic       exp_ovf [6];
      exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 20'h40000;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); @(negedge clk);
         n_total++; if (level !== exp_lvl[i] || wr_ready !== exp_rdy[i] || ovf !== exp_ovf[i])
            $display("FAIL ovf_step%0d: got lvl %0d rdy %b ovf %b want lvl %0d rdy %b ovf %b",
                     i, level, wr_ready, ovf, exp_lvl[i], exp_rdy[i], exp_ovf[i]);
         else n_pass++;
      end
      clr_ovf = 1'b1;
      @(posedge clk); @(negedge clk);
      n_total++; if (ovf !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", ovf); else n_pass++;
      wr_valid = 1'b0;
      clr_ovf  = 1'b0;
      @(posedge clk); @(negedge clk);
      n_total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else n_pass++;
      clr_ovf = 1'b1;
      @(posedge clk); @(negedge clk);
      clr_ovf = 1'b0;
      n_total++; if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf); else n_pass++;
      // Flush with a (would-be refused) write in the same cycle.
      flush    = 1'b1;
      wr_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      flush    = 1'b0;
      wr_valid = 1'b0;
      n_total++; if (level !== 3'd0 || key !== 1'b0 || busy !== 1'b0)
         $display("FAIL flush_state: got lvl %0d key %b busy %b want 0 0 0", level, key, busy); else n_pass++;
      n_total++; if (ovf !== 1'b0 || wr_ready !== 1'b1)
         $display("FAIL flush_ovf: got ovf %b rdy %b want 0 1", ovf, wr_ready); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      wr(20'h80000);
      wr(20'h40000);
      wr(20'h40000);
      // Dash started on edge t+2; we are now just after t+2.
      repeat (3) @(negedge clk);
      n_total++; if (key !== 1'b1 || level !== 3'd2)
         $display("FAIL rm_pre: got key %b lvl %0d want 1 2", key, level); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++; if (key !== 1'b0) $display("FAIL rm_key: got %b want 0", key); else n_pass++;
      n_total++; if (level !== 3'd0 || busy !== 1'b0 || ovf !== 1'b0)
         $display("FAIL rm_state: got lvl %0d busy %b ovf %b want 0 0 0", level, busy, ovf); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_single_e("rm_e");
   endtask

   initial begin
      test_reset();
      test_single_e("e");
      test_a();
      test_e_wspace();
      test_dots();
      test_overflow_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
